// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8-bit asynchronous serial receiver with a show-ahead receive FIFO.
//
// The line is oversampled at 16x the baud rate. Frames are 8N1 by default, or 8E1 when
// UART_RX_PARITY_EN is defined. Received bytes are buffered in a FIFO and presented on a
// valid/ready stream.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   UART_RXD      asynchronous serial line, idle high
//   rx_data       FIFO head byte, meaningful while rx_valid=1
//   rx_valid      FIFO non-empty
//   rx_ready      consumer pops the head when rx_valid && rx_ready at a rising edge
//   fifo_count    FIFO occupancy, 0..FIFO_DEPTH
//   framing_error one-cycle pulse: stop bit sampled low
//   overrun       one-cycle pulse: completed byte dropped because the FIFO was full
//   parity_error  one-cycle pulse: even-parity mismatch (tied low without UART_RX_PARITY_EN)
//
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing with a parity check).

module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              UART_RXD,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              framing_error,
    output logic              overrun,
    output logic              parity_error
);

    // Oversample divider, rounded to nearest.
    localparam int unsigned DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]     DIV_LAST = DW'(DIV - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = FIFO_DEPTH[ADDR_W:0];

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e        state_q, state_d;
    logic          rxd_meta_q, rxd_sync_q;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          ovr_q, ovr_d;
    logic          tick;
    logic          par_bad;

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    // Even parity: the parity bit equals the XOR of the data bits.
    assign par_bad = par_bit_q != (^shift_q);
`else
    assign par_bad = 1'b0;
`endif

    assign tick = (state_q != StIdle) && (div_q == DIV_LAST);

    // Receiver next-state logic.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
`endif
        if (state_q != StIdle) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                div_d      = '0;
                tick_cnt_d = '0;
                if (!rxd_sync_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick && tick_cnt_q == 4'd7) begin
                    if (rxd_sync_q) begin
                        state_d = StIdle;  // false start
                    end else begin
                        state_d    = StData;
                        tick_cnt_d = '0;   // later samples land 16 ticks apart, mid-bit
                        bit_idx_d  = '0;
                    end
                end
            end
            StData: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    shift_d   = {rxd_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    par_bit_d = rxd_sync_q;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    if (!rxd_sync_q) begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end else if (par_bad) begin
                        perr_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        push_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StBreak: begin
                // Wait for the line to return high so a break is not seen as new starts.
                if (rxd_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO.
    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty, full, do_pop, do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = !empty && rx_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push_q && (!full || do_pop);
    assign ovr_d   = push_q && full && !do_pop;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rxd_meta_q <= UART_RXD;
            rxd_sync_q <= rxd_meta_q;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
            count_q    <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_data       = mem[rd_ptr_q];
    assign rx_valid      = !empty;
    assign fifo_count    = count_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;
    assign parity_error  = perr_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Standalone 8-bit asynchronous serial receiver, the receive end of the board's UART_RXD/UART_TXD serial link.
- Oversamples the incoming line at 16x the baud rate and de-frames 8N1 characters.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream interface to a local consumer (custom logic or a Nios II PIO/bridge).

Parameters:
CLK_FREQ  50000000  system clock frequency in Hz
BAUD  115200  line rate in bit/s; oversample divider DIV = round(CLK_FREQ/(BAUD*16)) = 27 at defaults
FIFO_DEPTH  16  receive FIFO entries; power of two, minimum 2
ADDR_W  4  log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock, CLOCK_50 domain
reset  input  1  synchronous, active-high reset
UART_RXD  input  1  asynchronous serial line, idle high
rx_data  output  8  FIFO head byte; valid only while rx_valid=1
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts head when rx_valid && rx_ready at a rising edge
fifo_count  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because FIFO was full
parity_error  output  1  one-cycle pulse: parity mismatch (constant 0 unless UART_RX_PARITY_EN)

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port reset. All state updates on the rising edge of clk.
- Reset values:
  - rx_valid=0, fifo_count=0, all error pulses 0.
  - FIFO read/write pointers 0; state IDLE.
  - Two-flop synchronizer on UART_RXD resets to 1.
  - rx_data is don't-care after reset.
- Tick generator: a counter 0..DIV-1 produces a one-cycle tick at DIV-1. It is held at 0 in IDLE and restarted on leaving IDLE. A sample counter (4 bits) counts ticks.
- FSM:
  - IDLE: on synchronized line = 0, go to START and clear counters.
  - START: at tick count 7 (mid-bit), sample. If 1, it is a false start: return to IDLE with no output. If 0, go to DATA with bit index 0.
  - DATA: every 16 ticks, sample the line into a shift register, LSB first. After bit 7, go to STOP (or PARITY when the macro is defined).
  - PARITY (macro only): sample after 16 ticks, then go to STOP.
  - STOP: sample after 16 ticks.
    - Sample 1 and no parity error: issue a push request. Go to IDLE.
    - Sample 0: pulse framing_error, discard the byte, go to BREAK_WAIT.
  - BREAK_WAIT: stay until the synchronized line = 1, then go to IDLE. Covers break conditions without re-triggering.
- Latency: the push occurs on the edge following the stop-bit sample, and rx_valid is high from the next cycle. Synchronizer adds 2 cycles on input.
- FIFO:
  - Show-ahead; rx_data = mem[rd_ptr].
  - Pointers wrap modulo FIFO_DEPTH; count tracks occupancy.
  - Pop when rx_valid && rx_ready.
  - Push when full and no simultaneous pop: byte dropped, overrun pulses, count stays FIFO_DEPTH.
  - Push and pop in the same cycle: both take effect, count unchanged. This applies at full as well (no overrun).
  - rx_ready while empty: ignored.
- Error pulses are mutually exclusive per frame and are one clk cycle wide, coincident with the discard decision.
- Reset mid-frame: the partial frame is abandoned and the FIFO is flushed. The receiver resumes in IDLE; if the line is still low, a spurious start may be taken, which is resolved by the false-start or framing rules.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the frame is 8E1. A PARITY state samples the bit after D7. Mismatch against even parity of the data pulses parity_error with the STOP-state timing, and the byte is discarded; framing_error takes precedence if the stop bit is also 0.
- Undefined: 8N1, no PARITY state, parity_error tied to 0.

Test Plan:
- Idle line, rx_ready=1, send 0x55 at 115200 (432 clk/bit) -> rx_valid high one cycle with rx_data=0x55; fifo_count returns 1->0; no error pulses.
- Low glitch of 100 clk on an idle line -> no push, no error pulses, FSM back in IDLE; a following frame 0x81 is received correctly.
- Frame 0xA3 with stop bit 0, line then low for 2 bit times, then high -> one framing_error pulse, fifo_count=0; next frame 0x3C is received as 0x3C.
- rx_ready=0, send 17 frames 0x00..0x10:
  - fifo_count=16 after the 16th frame.
  - overrun pulses once on the 17th.
  - Then rx_ready=1 drains 0x00..0x0F in order and fifo_count reaches 0.
- Assert reset for 1 cycle after 4 data bits of a frame -> fifo_count=0, rx_valid=0; the next full frame 0xFF is received as 0xFF.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_error pulse, no push; 0x07 with parity bit 1 -> rx_data=0x07.
